// File: rtl/rol_pkg.sv
// Shared types and constants for the iterative 16-bit rotate-left unit.
package rol_pkg;
  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [AMT_W-1:0] amt_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rol_state_e;
endpackage

// File: rtl/rol_iter_if.sv
// Request/result bundle for rol_iter.
// Handshake: start is honoured only on an edge where busy is low; that edge
// captures data_in/amount. busy stays high while the operation is in flight.
// done pulses for exactly one cycle, and data_out is valid from that cycle
// until the next done.
interface rol_iter_if;
  import rol_pkg::*;

  logic  start;
  data_t data_in;
  amt_t  amount;
  logic  busy;
  logic  done;
  data_t data_out;

  modport master (output start, data_in, amount, input busy, done, data_out);
  modport slave  (input start, data_in, amount, output busy, done, data_out);
endinterface

// File: rtl/rol_stage.sv
// One logarithmic rotate-left stage: rotates by 2^k when en is high,
// otherwise passes the operand through unchanged.
module rol_stage
  import rol_pkg::*;
(
  input  logic [1:0] k,
  input  logic       en,
  input  data_t      din,
  output data_t      dout
);

  // Select the rotate distance for the active stage.
  always_comb begin
    dout = din;
    if (en) begin
      case (k)
        2'd0: dout = {din[14:0], din[15]};
        2'd1: dout = {din[13:0], din[15:14]};
        2'd2: dout = {din[11:0], din[15:12]};
        2'd3: dout = {din[7:0],  din[15:8]};
      endcase
    end
  end

endmodule

// File: rtl/rol_iter.sv
// Multi-cycle 16-bit rotate-left: one logarithmic stage (1, 2, 4, 8) per
// clock, with a start/busy/done handshake and a held result register.
// Optional build macro: ROL_EARLY_EXIT_EN -- finish on the stage that
// applies the highest set bit of the amount instead of always running 4.
module rol_iter
  import rol_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  rol_iter_if.slave     bus,
  output rol_state_e    dbg_state,
  output logic [1:0]    dbg_stg
);

  rol_state_e state_q, state_n;
  logic [1:0] stg_q, stg_n;
  data_t      work_q, work_n;
  amt_t       amt_q, amt_n;
  data_t      out_q, out_n;
  logic       done_q, done_n;

  data_t      stage_out;
  logic       last_stage;

  rol_stage u_stage (
    .k    (stg_q),
    .en   (amt_q[stg_q]),
    .din  (work_q),
    .dout (stage_out)
  );

  // Decide whether the current RUN stage is the final one.
  always_comb begin
`ifdef ROL_EARLY_EXIT_EN
    last_stage = (stg_q == 2'd3) ||
                 ((amt_q >> ({1'b0, stg_q} + 3'd1)) == '0);
`else
    last_stage = (stg_q == 2'd3);
`endif
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stg_q   <= 2'd0;
      work_q  <= '0;
      amt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      stg_q   <= stg_n;
      work_q  <= work_n;
      amt_q   <= amt_n;
      out_q   <= out_n;
      done_q  <= done_n;
    end
  end

  // Next-state and datapath control; done is a one-edge pulse by default.
  always_comb begin
    state_n = state_q;
    stg_n   = stg_q;
    work_n  = work_q;
    amt_n   = amt_q;
    out_n   = out_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_n  = bus.data_in;
          amt_n   = bus.amount;
          stg_n   = 2'd0;
          state_n = RUN;
        end
      end
      RUN: begin
        work_n = stage_out;
        stg_n  = stg_q + 2'd1;
        if (last_stage) begin
          out_n   = stage_out;
          done_n  = 1'b1;
          stg_n   = 2'd0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.busy     = (state_q == RUN);
    bus.done     = done_q;
    bus.data_out = out_q;
    dbg_state    = state_q;
    dbg_stg      = stg_q;
  end

endmodule

// File: tb/tb_rol_iter.sv
// Self-checking bench for rol_iter: driver tasks push expected results into
// a scoreboard queue, a monitor pops and compares on every done pulse.
module tb_rol_iter;
  import rol_pkg::*;

  logic       clk;
  logic       rst_n;
  rol_state_e dbg_state;
  logic [1:0] dbg_stg;

  rol_iter_if bus ();

  rol_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_stg   (dbg_stg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               acc_q[$];
  int               lat_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: rotate left one bit at a time, amount times.
  function automatic logic [WIDTH-1:0] ref_rol(input logic [WIDTH-1:0] d,
                                               input int a);
    logic [WIDTH-1:0] r;
    r = d;
    for (int i = 0; i < a; i++) r = {r[WIDTH-2:0], r[WIDTH-1]};
    return r;
  endfunction

  // Reference latency in edges from acceptance to the done edge.
  function automatic int ref_lat(input int a);
`ifdef ROL_EARLY_EXIT_EN
    int l;
    l = 1;
    for (int i = 1; i < 4; i++) if ((a >> i) != 0) l = i + 1;
    return l;
`else
    return 4;
`endif
  endfunction

  // Driver: wait for idle, present one request, record expectation.
  task automatic issue(input logic [WIDTH-1:0] d, input logic [3:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("issue_wait_timeout", 32'd1, 32'd0);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.amount  = a;
    @(posedge clk);
    #1;
    exp_q.push_back(ref_rol(d, int'(a)));
    acc_q.push_back(cyc);
    lat_q.push_back(ref_lat(int'(a)));
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = WIDTH'($urandom);
    bus.amount  = 4'($urandom);
  endtask

  // Raise start for one cycle while the unit is busy; must be ignored.
  task automatic poke(input logic [WIDTH-1:0] d, input logic [3:0] a);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.amount  = a;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor / scoreboard.
  initial begin : monitor
    logic [WIDTH-1:0] last_out;
    logic             prev_done;
    int               a_cyc;
    int               lat;
    last_out  = '0;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        last_out  = '0;
        prev_done = 1'b0;
      end else if (bus.done) begin
        if (prev_done) chk("done_single_cycle", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          a_cyc = acc_q.pop_front();
          lat   = lat_q.pop_front();
          chk("result", {16'd0, bus.data_out}, {16'd0, exp_q.pop_front()});
          chk("latency", 32'(cyc - a_cyc), 32'(lat));
          chk("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
        end
        last_out  = bus.data_out;
        prev_done = 1'b1;
      end else begin
        chk("data_out_hold", {16'd0, bus.data_out}, {16'd0, last_out});
        prev_done = 1'b0;
      end
    end
  end

  // Stimulus.
  initial begin : stim
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.amount  = '0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_data_out", {16'd0, bus.data_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, issued back-to-back so later starts land in done cycles.
    issue(16'h8001, 4'd1);
    issue(16'h1234, 4'd4);
    issue(16'h1234, 4'd8);
    issue(16'hA5C3, 4'd15);
    issue(16'hBEEF, 4'd0);
    issue(16'h0F0F, 4'd3);
    drain();

    // start while busy is ignored.
    issue(16'hC001, 4'd9);
    poke(16'hFFFF, 4'd2);
    poke(16'h1111, 4'd5);
    drain();

    // Reset mid-operation (after E2): aborts without a done pulse.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'h7777;
    bus.amount  = 4'd12;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_data_out", {16'd0, bus.data_out}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_pending", 32'(exp_q.size()), 32'd0);
    issue(16'h4321, 4'd6);
    drain();

    // Random traffic with random idle gaps.
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(WIDTH'($urandom), 4'($urandom_range(0, 15)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
